param_sequence_detector: RTL and testbench

PARAM_SEQUENCE_DETECTOR -- requirements
Module: param_sequence_detector

---
 rtl/param_sequence_detector.sv | 104 ++++++++++
 tb/tb_param_sequence_detector.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/param_sequence_detector.sv
// Serial pattern detector with overlapping/non-overlapping modes and a match counter.
// Build option: define SEQ_DET_SATURATE_EN to make the match counter saturate instead of wrap.
module param_sequence_detector #(
    parameter int unsigned          PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0]   PATTERN = 3'b010,
    parameter int unsigned          CNT_W   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             en,
    input  logic             overlap,
    input  logic             clr_count,
    output logic             y,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned        FILL_W    = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
    localparam logic [FILL_W-1:0]  FILL_LAST = FILL_W'(PAT_LEN - 1);
    localparam logic [FILL_W-1:0]  FILL_ONE  = FILL_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

    logic [PAT_LEN-2:0] hist_q,  hist_d;
    logic [FILL_W-1:0]  fill_q,  fill_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               y_q,     y_d;
    logic [PAT_LEN-1:0] window_s;
    logic               match_s;

    // State register: asynchronous reset discards all history and the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q  <= '0;
            fill_q  <= '0;
            count_q <= '0;
            y_q     <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            count_q <= count_d;
            y_q     <= y_d;
        end
    end

    // Match detection: only a fully filled window may match.
    always_comb begin
        window_s = {hist_q, x};
        match_s  = 1'b0;
        if (en && (fill_q == FILL_LAST) && (window_s == PATTERN)) begin
            match_s = 1'b1;
        end else begin
            match_s = 1'b0;
        end
    end

    // History and fill tracking; a non-overlapping match restarts the fill.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (en) begin
            hist_d = window_s[PAT_LEN-2:0];
            if (match_s) begin
                if (overlap) begin
                    fill_d = fill_q;
                end else begin
                    fill_d = '0;
                end
            end else if (fill_q == FILL_LAST) begin
                fill_d = fill_q;
            end else begin
                fill_d = fill_q + FILL_ONE;
            end
        end else begin
            hist_d = hist_q;
            fill_d = fill_q;
        end
    end

    // Match pulse and counter; clear wins over a simultaneous match.
    always_comb begin
        y_d     = match_s;
        count_d = count_q;
        if (clr_count) begin
            count_d = '0;
        end else if (match_s) begin
`ifdef SEQ_DET_SATURATE_EN
            if (count_q == CNT_MAX) begin
                count_d = count_q;
            end else begin
                count_d = count_q + CNT_ONE;
            end
`else
            count_d = count_q + CNT_ONE;
`endif
        end else begin
            count_d = count_q;
        end
    end

    assign y     = y_q;
    assign count = count_q;

endmodule

// File: tb/tb_param_sequence_detector.sv
// Directed self-checking bench for param_sequence_detector (default, CNT_W=2 and PAT_LEN=4 builds).
module tb_param_sequence_detector;

    logic       clk;
    logic       rst;
    logic       x;
    logic       en;
    logic       overlap;
    logic       clr_count;
    logic       y_a;
    logic [9:0] count_a;
    logic       y_c2;
    logic [1:0] count_c2;
    logic       y_p4;
    logic [9:0] count_p4;

    int n_checks;
    int n_errors;

    param_sequence_detector u_dut_a (
        .clk(clk), .rst(rst), .x(x), .en(en), .overlap(overlap),
        .clr_count(clr_count), .y(y_a), .count(count_a)
    );

    param_sequence_detector #(.CNT_W(2)) u_dut_c2 (
        .clk(clk), .rst(rst), .x(x), .en(en), .overlap(overlap),
        .clr_count(clr_count), .y(y_c2), .count(count_c2)
    );

    param_sequence_detector #(.PAT_LEN(4), .PATTERN(4'b1101)) u_dut_p4 (
        .clk(clk), .rst(rst), .x(x), .en(en), .overlap(overlap),
        .clr_count(clr_count), .y(y_p4), .count(count_p4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic y_of(input int sel);
        if (sel == 1) return y_c2;
        else if (sel == 2) return y_p4;
        else return y_a;
    endfunction

    function automatic logic [31:0] count_of(input int sel);
        if (sel == 1) return 32'(count_c2);
        else if (sel == 2) return 32'(count_p4);
        else return 32'(count_a);
    endfunction

    task automatic send(input logic b, input logic e, input logic c);
        @(negedge clk);
        x         = b;
        en        = e;
        clr_count = c;
        @(posedge clk);
        #1;
        en        = 1'b0;
        clr_count = 1'b0;
    endtask

    // bits and exp_y are read left to right: bit n-1 is sent first
    task automatic run(input string tag, input int sel, input int n,
                       input logic [15:0] bits, input logic [15:0] exp_y);
        for (int i = n - 1; i >= 0; i--) begin
            send(bits[i], 1'b1, 1'b0);
            check($sformatf("%s_y%0d", tag, n - i), 32'(y_of(sel)), 32'(exp_y[i]));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_sat;
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        x         = 1'b0;
        en        = 1'b0;
        overlap   = 1'b1;
        clr_count = 1'b0;
        #12;
        check("reset_y", 32'(y_a), 32'd0);
        check("reset_count", count_of(0), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // overlapping: 0,1,0,1,0 -> pulses after bits 3 and 5
        overlap = 1'b1;
        run("ovl", 0, 5, 16'b01010, 16'b00101);
        check("ovl_count", count_of(0), 32'd2);
        send(1'b0, 1'b0, 1'b0);
        check("ovl_idle_y", 32'(y_a), 32'd0);

        // non-overlapping
        do_reset();
        overlap = 1'b0;
        run("novl_a", 0, 5, 16'b01010, 16'b00100);
        check("novl_a_count", count_of(0), 32'd1);
        do_reset();
        run("novl_b", 0, 6, 16'b010010, 16'b001001);
        check("novl_b_count", count_of(0), 32'd2);

        // en gap: zeros presented while en=0 must be ignored
        do_reset();
        overlap = 1'b1;
        run("gap_pre", 0, 2, 16'b01, 16'b00);
        for (int i = 0; i < 4; i++) begin
            send(1'b0, 1'b0, 1'b0);
            check($sformatf("gap_y%0d", i), 32'(y_a), 32'd0);
        end
        check("gap_count_hold", count_of(0), 32'd0);
        send(1'b0, 1'b1, 1'b0);
        check("gap_final_y", 32'(y_a), 32'd1);
        check("gap_count", count_of(0), 32'd1);

        // asynchronous reset mid-cycle and mid-pattern
        do_reset();
        overlap = 1'b0;
        run("ar_pre", 0, 3, 16'b010, 16'b001);
        #2;
        rst = 1'b1;
        #1;
        check("ar_async_y", 32'(y_a), 32'd0);
        check("ar_async_count", count_of(0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run("ar_part", 0, 2, 16'b01, 16'b00);
        #2;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run("ar_post", 0, 4, 16'b0010, 16'b0001);
        check("ar_post_count", count_of(0), 32'd1);

        // narrow counter, five overlapping matches
        do_reset();
        overlap = 1'b1;
        run("c2", 1, 11, 16'b01010101010, 16'b00101010101);
`ifdef SEQ_DET_SATURATE_EN
        exp_sat = 32'd3;
`else
        exp_sat = 32'd1;
`endif
        check("c2_count", count_of(1), exp_sat);

        // clear coinciding with a match
        do_reset();
        overlap = 1'b1;
        run("clr_pre", 0, 4, 16'b0101, 16'b0010);
        check("clr_pre_count", count_of(0), 32'd1);
        send(1'b0, 1'b1, 1'b1);
        check("clr_y", 32'(y_a), 32'd1);
        check("clr_count", count_of(0), 32'd0);

        // 4-bit pattern 1101, overlapping
        do_reset();
        overlap = 1'b1;
        run("p4", 2, 7, 16'b1101101, 16'b0001001);
        check("p4_count", count_of(2), 32'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
